// File: rtl/stream_demux_32b_1to2.sv
// rtl/stream_demux_32b_1to2.sv - registered 1:2 word demux with an independent FIFO per output
// A stalled consumer only backpressures words steered to its own port.
module stream_demux_32b_1to2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    count0,
  output logic [CW-1:0]    count1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]            w_full;
  logic [1:0]            w_valid;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_out_ready;
  logic [1:0][CW-1:0]    w_count;
  logic [1:0][WIDTH-1:0] w_head;

  // in_ready comes from registered occupancy only, so a full port never passes through
  assign in_ready    = !w_full[in_sel];
  assign w_push[0]   = in_valid && in_ready && !in_sel;
  assign w_push[1]   = in_valid && in_ready && in_sel;
  assign w_out_ready = {out1_ready, out0_ready};
  assign w_pop       = w_valid & w_out_ready;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PW'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PW'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage needs no reset: data is gated to zero whenever the port is empty
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wptr] <= in_data;
    end

    assign w_count[g] = r_count;
    assign w_full[g]  = (r_count == CW'(DEPTH));
    assign w_valid[g] = (r_count != '0);
    assign w_head[g]  = w_valid[g] ? r_mem[r_rptr] : '0;
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign count0     = w_count[0];
  assign count1     = w_count[1];

`ifndef SYNTHESIS
  a_no_x_sel: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(in_sel));
`endif

endmodule
